// File: rtl/merger_out_buffer.sv
// rtl/merger_out_buffer.sv - output FIFO behind a 2-tuple merger with slack-ready, sort check and run counting
module merger_out_buffer #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int DEPTH      = 16,
    parameter int SLACK      = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [2*DATA_WIDTH-1:0]     i_data,
    input  logic                        i_write,
    output logic                        o_ready,
    output logic [2*DATA_WIDTH-1:0]     o_data,
    output logic                        o_empty,
    input  logic                        i_read,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_run_done,
    output logic [15:0]                 o_runs,
    output logic                        o_overrun,
    output logic                        o_underrun,
    output logic                        o_order_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - SLACK);

    logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 run_done_q, run_done_d;
    logic [15:0]          runs_q, runs_d;
    logic                 overrun_q, overrun_d;
    logic                 underrun_q, underrun_d;
    logic                 order_err_q, order_err_d;
    logic [KEY_WIDTH-1:0] last_key_q, last_key_d;
    logic                 last_valid_q, last_valid_d;

    logic                 rd_acc, wr_acc;
    logic                 in_term, head_term;
    logic [KEY_WIDTH-1:0] key0, key1;

    always_comb begin
        key0      = i_data[KEY_WIDTH-1:0];
        key1      = i_data[DATA_WIDTH+KEY_WIDTH-1:DATA_WIDTH];
        in_term   = (i_data[DATA_WIDTH-1:0] == '0);
        head_term = (mem_q[rd_ptr_q][DATA_WIDTH-1:0] == '0);
        rd_acc    = i_read && (count_q != '0);
        // A full buffer still takes a write when the head leaves in the same cycle.
        wr_acc    = i_write && ((count_q != FULL) || rd_acc);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overrun_d    = overrun_q;
        underrun_d   = underrun_q;
        order_err_d  = order_err_q;
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q;
        run_done_d   = 1'b0;
        runs_d       = runs_q;

        if (wr_acc)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc)
            rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (i_write && !wr_acc)
            overrun_d = 1'b1;
        if (i_read && !rd_acc)
            underrun_d = 1'b1;

        // Terminators reset the run; other beats are checked within and across beats.
        if (wr_acc) begin
            if (in_term) begin
                last_valid_d = 1'b0;
            end else begin
                if ((key0 > key1) || (last_valid_q && (key0 < last_key_q)))
                    order_err_d = 1'b1;
                last_key_d   = key1;
                last_valid_d = 1'b1;
            end
        end

        if (rd_acc && head_term) begin
            run_done_d = 1'b1;
            runs_d     = runs_q + 16'd1;
        end

        ready_d = (count_d <= READY_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            run_done_q   <= 1'b0;
            runs_q       <= '0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            order_err_q  <= 1'b0;
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            run_done_q   <= run_done_d;
            runs_q       <= runs_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            order_err_q  <= order_err_d;
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_data      = mem_q[rd_ptr_q];
    assign o_empty     = (count_q == '0);
    assign o_count     = count_q;
    assign o_run_done  = run_done_q;
    assign o_runs      = runs_q;
    assign o_overrun   = overrun_q;
    assign o_underrun  = underrun_q;
    assign o_order_err = order_err_q;

endmodule

// File: tb/tb_merger_out_buffer.sv
// tb/tb_merger_out_buffer.sv - randomized self-checking bench for merger_out_buffer
module tb_merger_out_buffer;

    localparam int DW = 128;
    localparam int KW = 80;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [2*DW-1:0] i_data = '0;
    logic            i_write = 1'b0;
    logic            i_read = 1'b0;
    logic            o_ready;
    logic [2*DW-1:0] o_data;
    logic            o_empty;
    logic [4:0]      o_count;
    logic            o_run_done;
    logic [15:0]     o_runs;
    logic            o_overrun, o_underrun, o_order_err;

    always #5 clk = ~clk;

    merger_out_buffer dut (
        .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_write(i_write),
        .o_ready(o_ready), .o_data(o_data), .o_empty(o_empty), .i_read(i_read),
        .o_count(o_count), .o_run_done(o_run_done), .o_runs(o_runs),
        .o_overrun(o_overrun), .o_underrun(o_underrun), .o_order_err(o_order_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] pend[$];
    logic            m_over, m_under, m_oe, m_lv, m_rdone, m_ready;
    logic [KW-1:0]   m_lk;
    logic [15:0]     m_runs;

    task automatic chk(input string tag, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*DW-1:0] mk(input logic [KW-1:0] k0, input logic [KW-1:0] k1);
        logic [47:0] u0, u1;
        u0 = {$urandom(), 16'($urandom())};
        u1 = {$urandom(), 16'($urandom())};
        return {u1, k1, u0, k0};
    endfunction

    function automatic logic [2*DW-1:0] term();
        logic [2*DW-1:0] b;
        b = mk(80'($urandom()), 80'd0);
        b[DW-1:0] = '0;
        return b;
    endfunction

    task automatic check_all();
        chk("count", 256'(o_count), 256'(q.size()));
        chk("empty", 256'(o_empty), 256'(q.size() == 0));
        chk("ready", 256'(o_ready), 256'(m_ready));
        if (q.size() > 0) chk("data", o_data, q[0]);
        chk("overrun", 256'(o_overrun), 256'(m_over));
        chk("underrun", 256'(o_underrun), 256'(m_under));
        chk("order_err", 256'(o_order_err), 256'(m_oe));
        chk("runs", 256'(o_runs), 256'(m_runs));
        chk("run_done", 256'(o_run_done), 256'(m_rdone));
    endtask

    task automatic cyc(input logic wr, input logic [2*DW-1:0] d, input logic rd);
        logic rd_ok, wr_ok;
        logic [2*DW-1:0] head;
        @(negedge clk);
        i_rst = 1'b0; i_write = wr; i_data = d; i_read = rd;
        rd_ok = rd && q.size() > 0;
        wr_ok = wr && (q.size() < 16 || rd_ok);
        if (rd && !rd_ok) m_under = 1'b1;
        if (wr && !wr_ok) m_over = 1'b1;
        if (wr_ok) begin
            if (d[DW-1:0] == '0) m_lv = 1'b0;
            else begin
                if (d[KW-1:0] > d[DW+KW-1:DW] || (m_lv && d[KW-1:0] < m_lk)) m_oe = 1'b1;
                m_lk = d[DW+KW-1:DW];
                m_lv = 1'b1;
            end
        end
        m_rdone = 1'b0;
        if (rd_ok) begin
            head = q.pop_front();
            if (head[DW-1:0] == '0) begin
                m_rdone = 1'b1;
                m_runs++;
            end
        end
        if (wr_ok) q.push_back(d);
        m_ready = (q.size() <= 12);
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_rst();
        @(negedge clk);
        i_rst = 1'b1; i_write = 1'b0; i_read = 1'b0;
        q.delete();
        m_over = 0; m_under = 0; m_oe = 0; m_lv = 0; m_rdone = 0; m_ready = 0;
        m_lk = '0; m_runs = '0;
        @(posedge clk); #1;
        check_all();
    endtask

    initial begin
        int pulses, guard;
        logic [KW-1:0] k, k1;
        logic wr, rd;

        // reset state and underrun on empty
        do_rst();
        chk("rst_ready", 256'(o_ready), 256'(0));
        cyc(1'b0, '0, 1'b1);
        chk("t5_underrun", 256'(o_underrun), 256'(1));
        chk("t5_count", 256'(o_count), 256'(0));
        chk("t5_empty", 256'(o_empty), 256'(1));

        // fill, slack-ready, overflow handling
        do_rst();
        for (int i = 0; i < 13; i++) cyc(1'b1, mk(80'(2*i+1), 80'(2*i+2)), 1'b0);
        chk("t1_count", 256'(o_count), 256'(13));
        chk("t1_ready", 256'(o_ready), 256'(0));
        chk("t1_overrun", 256'(o_overrun), 256'(0));
        for (int i = 13; i < 16; i++) cyc(1'b1, mk(80'(2*i+1), 80'(2*i+2)), 1'b0);
        cyc(1'b1, mk(80'd40, 80'd41), 1'b0);
        chk("t2_overrun", 256'(o_overrun), 256'(1));
        chk("t2_count", 256'(o_count), 256'(16));
        cyc(1'b1, mk(80'd42, 80'd43), 1'b1);
        chk("t2_count_rw", 256'(o_count), 256'(16));
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);

        // ordering and run counting
        do_rst();
        cyc(1'b1, mk(80'd1, 80'd3), 1'b0);
        cyc(1'b1, mk(80'd5, 80'd9), 1'b0);
        cyc(1'b1, term(), 1'b0);
        cyc(1'b1, mk(80'd2, 80'd4), 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, !o_empty);
            if (o_run_done) pulses++;
        end
        chk("t3_pulses", 256'(pulses), 256'(1));
        chk("t3_runs", 256'(o_runs), 256'(1));
        chk("t3_order", 256'(o_order_err), 256'(0));

        do_rst();
        cyc(1'b1, mk(80'd5, 80'd9), 1'b0);
        cyc(1'b1, mk(80'd7, 80'd8), 1'b0);
        chk("t4_cross", 256'(o_order_err), 256'(1));
        do_rst();
        cyc(1'b1, mk(80'd9, 80'd4), 1'b0);
        chk("t4_within", 256'(o_order_err), 256'(1));

        // reset mid-operation, then random sorted runs with stalls
        do_rst();
        for (int i = 0; i < 10; i++) cyc(1'b1, mk(80'(i+1), 80'(i+1)), 1'b0);
        do_rst();
        chk("t6_count", 256'(o_count), 256'(0));
        chk("t6_empty", 256'(o_empty), 256'(1));
        chk("t6_flags", 256'({o_overrun, o_underrun, o_order_err}), 256'(0));
        cyc(1'b0, '0, 1'b0);
        chk("t6_ready", 256'(o_ready), 256'(1));

        for (int r = 0; r < 24; r++) begin
            k = 80'($urandom_range(1, 1000)) | ({48'($urandom()), 32'd0});
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                k1 = k + 80'($urandom_range(0, 3));
                pend.push_back(mk(k, k1));
                k = k1 + 80'($urandom_range(0, 3));
            end
            pend.push_back(term());
        end
        guard = 0;
        while ((pend.size() > 0 || q.size() > 0) && guard < 5000) begin
            wr = (pend.size() > 0) && m_ready && ($urandom_range(0, 3) != 0);
            rd = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            cyc(wr, wr ? pend[0] : '0, rd);
            if (wr) void'(pend.pop_front());
            guard++;
        end
        chk("t6_drain_timeout", 256'(guard < 5000), 256'(1));
        chk("t6_runs", 256'(o_runs), 256'(24));
        chk("t6_final_flags", 256'({o_overrun, o_underrun, o_order_err}), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
